// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU convolution window fetcher.
//   ADDR_W  : scratch RAM address width (16384 x 8 RAM)
//   PIX_W   : pixel width
//   DIM_W   : width of the image dimension inputs
//   CNT_W   : width of the per-window fetch edge counter
package npu_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned DIM_W   = 8;
  localparam int unsigned WIN_PIX = 9;
  localparam int unsigned CNT_W   = 4;

  // Fetch edge counter: addresses issued on edges 0..8, pixels captured on edges 2..10.
  localparam logic [CNT_W-1:0] LastIssue   = 4'd8;
  localparam logic [CNT_W-1:0] LastCapture = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StOut,
    StFin
  } fetch_state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Address generator for the 3x3 window walk.
// Keeps the row pointer, output row/column and fetch edge counter, and registers the RAM
// read address. Row offsets come from stored img_w and 2*img_w, so no multiplier is used.
//   clock, reset_n     : clock, async active-low reset
//   load               : start accepted; latch geometry and issue address 0 of window (0,0)
//   fetch              : FSM is in FETCH; issue address k=cnt (for k<=8) and bump cnt
//   advance            : window handshake; step to the next window and issue its address 0
//   base_addr, img_w/h : scan geometry, sampled on load
//   ram_address        : registered RAM read address
//   cnt                : fetch edge counter (1 right after the edge that issues address 0)
//   col, row           : output column/row of the current window
//   last_window        : current window is the final one of the scan
module conv_addr_gen
  import npu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              fetch,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [ADDR_W-1:0] ram_address,
  output logic [CNT_W-1:0]  cnt,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              last_window
);

  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W:0]    w2_q, w2_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [ADDR_W-1:0] rowptr_q, rowptr_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              col_lt, row_lt;
  logic [ADDR_W-1:0] row_off;
  logic [1:0]        dc;
  logic [ADDR_W-1:0] fetch_addr;

  assign col_lt = col_q < (w_q - DIM_W'(3));
  assign row_lt = row_q < (h_q - DIM_W'(3));

  // Decode k = cnt into (dr*img_w, dc) for the tap being issued.
  always_comb begin
    row_off = '0;
    dc      = 2'd0;
    case (cnt_q)
      4'd1: dc = 2'd1;
      4'd2: dc = 2'd2;
      4'd3: row_off = ADDR_W'(w_q);
      4'd4: begin row_off = ADDR_W'(w_q);  dc = 2'd1; end
      4'd5: begin row_off = ADDR_W'(w_q);  dc = 2'd2; end
      4'd6: row_off = ADDR_W'(w2_q);
      4'd7: begin row_off = ADDR_W'(w2_q); dc = 2'd1; end
      4'd8: begin row_off = ADDR_W'(w2_q); dc = 2'd2; end
      default: ;
    endcase
  end

  // Sum truncates to ADDR_W, which gives the required wrap past the top of the RAM.
  assign fetch_addr = rowptr_q + row_off + ADDR_W'(col_q) + ADDR_W'(dc);

  always_comb begin
    w_d      = w_q;
    w2_d     = w2_q;
    h_d      = h_q;
    rowptr_d = rowptr_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    if (load) begin
      w_d      = img_w;
      w2_d     = {img_w, 1'b0};
      h_d      = img_h;
      rowptr_d = base_addr;
      col_d    = '0;
      row_d    = '0;
      cnt_d    = CNT_W'(1);
      addr_d   = base_addr;
    end else if (fetch) begin
      if (cnt_q <= LastIssue) begin
        addr_d = fetch_addr;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end else if (advance) begin
      if (col_lt) begin
        col_d  = col_q + DIM_W'(1);
        cnt_d  = CNT_W'(1);
        addr_d = rowptr_q + ADDR_W'(col_q) + ADDR_W'(1);
      end else if (row_lt) begin
        col_d    = '0;
        row_d    = row_q + DIM_W'(1);
        rowptr_d = rowptr_q + ADDR_W'(w_q);
        cnt_d    = CNT_W'(1);
        addr_d   = rowptr_q + ADDR_W'(w_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_q      <= '0;
      w2_q     <= '0;
      h_q      <= '0;
      rowptr_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
    end else begin
      w_q      <= w_d;
      w2_q     <= w2_d;
      h_q      <= h_d;
      rowptr_q <= rowptr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
    end
  end

  assign ram_address = addr_q;
  assign cnt         = cnt_q;
  assign col         = col_q;
  assign row         = row_q;
  assign last_window = !col_lt && !row_lt;

endmodule

// File: rtl/conv_window_fetch.sv
// Read-side sequencer for the convolution scratch RAM. Walks a row-major 8-bit image and
// emits every valid 3x3 window in raster order on a valid/ready stream.
//   clock, reset_n       : clock shared with the RAM, async active-low reset
//   start                : one-cycle scan request, sampled only in IDLE
//   base_addr, img_w/h   : scan geometry, sampled at start
//   busy, done, err      : status; done pulses one cycle, err flags a dimension below 3
//   ram_address, ram_q   : RAM read address (registered) and read data (2-edge latency)
//   win_valid/win_ready  : window stream handshake
//   win_data             : 9 pixels, slot k=3*dr+dc at bits [8k+7:8k]
//   win_row, win_col     : output position of the current window
module conv_window_fetch
  import npu_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [DIM_W-1:0]       img_w,
  input  logic [DIM_W-1:0]       img_h,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W-1:0]      ram_address,
  input  logic [PIX_W-1:0]       ram_q,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [WIN_PIX*PIX_W-1:0] win_data,
  output logic [DIM_W-1:0]       win_row,
  output logic [DIM_W-1:0]       win_col
);

  fetch_state_e state_q, state_d;
  logic         err_q, err_d;
  logic [WIN_PIX*PIX_W-1:0] win_q, win_d;

  logic             load, fetch, advance, last_window;
  logic [CNT_W-1:0] cnt;

  conv_addr_gen u_addr_gen (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .fetch       (fetch),
    .advance     (advance),
    .base_addr   (base_addr),
    .img_w       (img_w),
    .img_h       (img_h),
    .ram_address (ram_address),
    .cnt         (cnt),
    .col         (win_col),
    .row         (win_row),
    .last_window (last_window)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    win_d   = win_q;
    load    = 1'b0;
    fetch   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((img_w >= DIM_W'(3)) && (img_h >= DIM_W'(3))) begin
            load    = 1'b1;
            err_d   = 1'b0;
            state_d = StFetch;
          end else begin
            err_d   = 1'b1;
            state_d = StFin;
          end
        end
      end
      StFetch: begin
        fetch = 1'b1;
        // Data for the address issued on edge j arrives on edge j+2.
        for (int unsigned s = 0; s < WIN_PIX; s++) begin
          if (cnt == CNT_W'(s + 2)) begin
            win_d[s*PIX_W +: PIX_W] = ram_q;
          end
        end
        if (cnt == LastCapture) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (win_ready) begin
          advance = 1'b1;
          state_d = last_window ? StFin : StFetch;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      win_q   <= win_d;
    end
  end

  assign busy      = (state_q == StFetch) || (state_q == StOut);
  assign done      = (state_q == StFin);
  assign win_valid = (state_q == StOut);
  assign err       = err_q;
  assign win_data  = win_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Self-checking bench for conv_window_fetch: RAM model, window model and directed scans.
module tb_conv_window_fetch;
  import npu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [7:0]  img_w = '0;
  logic [7:0]  img_h = '0;
  logic        busy, done, err;
  logic [13:0] ram_address;
  logic [7:0]  ram_q;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [71:0] win_data;
  logic [7:0]  win_row, win_col;

  conv_window_fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .img_w       (img_w),
    .img_h       (img_h),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .win_row     (win_row),
    .win_col     (win_col)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [16384];
  always @(posedge clock) ram_q <= mem[ram_address];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [13:0] addr_tr  [4096];
  logic        valid_tr [4096];
  always @(negedge clock) begin
    if (cyc < 4096) begin
      addr_tr[cyc]  <= ram_address;
      valid_tr[cyc] <= win_valid;
    end
  end

  typedef struct packed {
    logic [71:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
  } win_t;

  typedef int addr9_t [9];

  win_t exp_q[$];
  win_t got[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [71:0] W00 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W11 = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
  localparam logic [71:0] WB  = {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102,
                                 8'd101, 8'd100};
  localparam logic [71:0] WD  = {8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd255, 8'd254, 8'd253,
                                 8'd252};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every valid window of the image, straight from the definition of a 3x3 valid window.
  task automatic model_scan(input int base, input int w, input int h);
    exp_q.delete();
    if (w < 3 || h < 3) return;
    for (int r = 0; r <= h - 3; r++) begin
      for (int c = 0; c <= w - 3; c++) begin
        win_t e;
        e.row = 8'(r);
        e.col = 8'(c);
        e.data = '0;
        for (int k = 0; k < 9; k++) begin
          int a;
          a = (base + (r + k / 3) * w + c + k % 3) % 16384;
          e.data[8*k +: 8] = mem[a];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // Compare process: every presented window must equal the model's next window.
  always @(negedge clock) begin
    if (reset_n && win_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window actual row=%0d col=%0d required none",
                 win_row, win_col);
      end else begin
        chk("win_data", 128'(win_data), 128'(exp_q[0].data));
        chk("win_row", 128'(win_row), 128'(exp_q[0].row));
        chk("win_col", 128'(win_col), 128'(exp_q[0].col));
        if (win_ready) begin
          got.push_back(exp_q[0]);
          got[got.size()-1].data = win_data;
          got[got.size()-1].row  = win_row;
          got[got.size()-1].col  = win_col;
          hs_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic kick(input int base, input int w, input int h, output int sc);
    model_scan(base, w, h);
    got.delete();
    hs_cyc.delete();
    base_addr = 14'(base);
    img_w     = 8'(w);
    img_h     = 8'(h);
    start     = 1'b1;
    @(posedge clock);
    #1;
    sc    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout actual=none required=done within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_addrs(input string name, input int sc, input addr9_t exp);
    for (int k = 0; k < 9; k++) begin
      chk(name, 128'(addr_tr[sc+k]), 128'(exp[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sc, dc, seen;
    bit found;
    addr9_t ea;

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_valid", 128'(win_valid), 128'(0));
    chk("rst_addr", 128'(ram_address), 128'(0));
    chk("rst_data", 128'(win_data), 128'(0));
    chk("rst_row", 128'(win_row), 128'(0));
    chk("rst_col", 128'(win_col), 128'(0));
    reset_n = 1'b1;
    tick();

    // A: 4x4, base 0, ready held high
    win_ready = 1'b1;
    kick(0, 4, 4, sc);
    chk("a_model_w00", 128'(exp_q[0].data), 128'(W00));
    chk("a_model_w11", 128'(exp_q[3].data), 128'(W11));
    chk("a_busy", 128'(busy), 128'(1));
    wait_done("a", 200, dc);
    chk("a_windows", 128'(got.size()), 128'(4));
    chk("a_model_left", 128'(exp_q.size()), 128'(0));
    chk("a_win00", 128'(got[0].data), 128'(W00));
    chk("a_win11", 128'(got[3].data), 128'(W11));
    ea = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    chk_addrs("a_addr", sc, ea);
    chk("a_valid_pre", 128'(valid_tr[sc+9]), 128'(0));
    chk("a_valid_lat", 128'(valid_tr[sc+10]), 128'(1));
    chk("a_period", 128'(hs_cyc[1] - hs_cyc[0]), 128'(11));
    chk("a_done_cyc", 128'(dc), 128'(hs_cyc[3] + 1));
    chk("a_done_busy", 128'(busy), 128'(0));
    @(negedge clock);
    chk("a_done_pulse", 128'(done), 128'(0));
    tick();

    // B: 5x3, base 100
    kick(100, 5, 3, sc);
    wait_done("b", 200, dc);
    chk("b_windows", 128'(got.size()), 128'(3));
    ea = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
    chk_addrs("b_addr", sc, ea);
    chk("b_win0", 128'(got[0].data), 128'(WB));
    for (int i = 0; i < 3; i++) chk("b_row", 128'(got[i].row), 128'(0));
    tick();

    // C: backpressure on the first window
    win_ready = 1'b0;
    kick(0, 4, 4, sc);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      found = win_valid;
    end
    chk("c_valid_seen", 128'(found), 128'(1));
    repeat (20) begin
      @(negedge clock);
      chk("c_hold_valid", 128'(win_valid), 128'(1));
      chk("c_hold_data", 128'(win_data), 128'(W00));
      chk("c_hold_addr", 128'(ram_address), 128'(10));
    end
    chk("c_no_hs", 128'(got.size()), 128'(0));
    tick();
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    repeat (15) @(negedge clock);
    chk("c_one_hs", 128'(got.size()), 128'(1));
    chk("c_next_valid", 128'(win_valid), 128'(1));
    chk("c_next_col", 128'(win_col), 128'(1));
    tick();
    win_ready = 1'b1;
    wait_done("c", 200, dc);
    chk("c_windows", 128'(got.size()), 128'(4));
    tick();

    // D: address wrap past the top of the RAM
    kick(16380, 3, 3, sc);
    wait_done("d", 200, dc);
    chk("d_windows", 128'(got.size()), 128'(1));
    ea = '{16380, 16381, 16382, 16383, 0, 1, 2, 3, 4};
    chk_addrs("d_addr", sc, ea);
    chk("d_win", 128'(got[0].data), 128'(WD));
    tick();

    // E: width below 3
    kick(0, 2, 5, sc);
    chk("e_err", 128'(err), 128'(1));
    chk("e_done", 128'(done), 128'(1));
    chk("e_busy", 128'(busy), 128'(0));
    chk("e_addr", 128'(ram_address), 128'(4));
    tick();
    chk("e_done_low", 128'(done), 128'(0));
    chk("e_err_held", 128'(err), 128'(1));
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (win_valid) seen++;
    end
    chk("e_no_valid", 128'(seen), 128'(0));
    chk("e_addr_end", 128'(ram_address), 128'(4));
    tick();

    // F: reset during FETCH of window 2, then replay
    kick(0, 4, 4, sc);
    chk("f_err_cleared", 128'(err), 128'(0));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      found = (got.size() >= 1);
    end
    chk("f_first_hs", 128'(found), 128'(1));
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("f_busy", 128'(busy), 128'(0));
    chk("f_done", 128'(done), 128'(0));
    chk("f_err", 128'(err), 128'(0));
    chk("f_valid", 128'(win_valid), 128'(0));
    chk("f_addr", 128'(ram_address), 128'(0));
    chk("f_data", 128'(win_data), 128'(0));
    chk("f_row", 128'(win_row), 128'(0));
    chk("f_col", 128'(win_col), 128'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    kick(0, 4, 4, sc);
    wait_done("f", 200, dc);
    chk("f_windows", 128'(got.size()), 128'(4));
    chk("f_replay_row", 128'(got[0].row), 128'(0));
    chk("f_replay_col", 128'(got[0].col), 128'(0));
    chk("f_replay_data", 128'(got[0].data), 128'(W00));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Read-side sequencer for the convolution scratch RAM, which is 16384 x 8, single-port, with a registered read.
- Walks an 8-bit image stored row-major at a base address and emits every 3x3 "valid" window (no padding) in raster order.
- Each window is 9 pixels, delivered on a valid/ready stream to the NPU MAC stage.
- Drives only the RAM address; the RAM arbiter holds wren low while busy=1.

Parameters:
- ADDR_W, 14, RAM address width; all address arithmetic is modulo 2^ADDR_W.
- PIX_W, 8, pixel width.
- DIM_W, 8, width of the image dimension inputs.

Ports:
- clock  in  1  rising-edge clock shared with the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  address of pixel (0,0); sampled at start.
- img_w  in  DIM_W  image width in pixels; sampled at start.
- img_h  in  DIM_W  image height in pixels; sampled at start.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse at completion.
- err  out  1  set when img_w<3 or img_h<3; cleared at the next accepted start.
- ram_address  out  ADDR_W  registered read address to the RAM.
- ram_q  in  PIX_W  RAM read data.
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_data  out  9*PIX_W  slot k=3*dr+dc occupies bits [8k+7:8k].
- win_row  out  DIM_W  output row index of the current window.
- win_col  out  DIM_W  output column index of the current window.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; busy, done, err, win_valid=0; ram_address, win_data, win_row, win_col=0. Asserting reset mid-operation aborts the scan; no partial window is ever presented.
- States: IDLE, FETCH, OUT, FIN.
- IDLE:
  - start=1 with img_w>=3 and img_h>=3: latch the inputs, set row=col=0, enter FETCH, busy=1.
  - start=1 with a dimension below 3: err=1, enter FIN; no RAM reads occur.
- FETCH (10 edges, counter k):
  - Edges 0..8 register ram_address = rowptr + dr*img_w + col + dc, where dr=k/3 and dc=k%3.
  - rowptr = base + row*img_w. Maintain it incrementally: add img_w once per output row. Hold img_w and 2*img_w in registers; no multiplier.
  - Read latency is 2 edges from address register to capture. Edges 2..10 capture ram_q into slot k-2.
  - Edge 10: enter OUT with win_valid=1.
- OUT: win_valid stays high and win_data, win_row, win_col stay stable until win_valid && win_ready at an edge. On that edge:
  - If col < img_w-3: col++, re-enter FETCH; the same edge issues address 0 of the next window.
  - Else if row < img_h-3: col=0, row++, rowptr += img_w, re-enter FETCH.
  - Else: enter FIN.
- Throughput: with win_ready held high, win_valid rises every 11 cycles (10 FETCH cycles plus 1 OUT cycle).
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Window count is (img_h-2)*(img_w-2).
- start while busy is ignored.
- Address overflow past 16383 wraps to 0.
- win_ready is ignored outside OUT.

Decomposition:
- Shared package npu_pkg: ADDR_W, PIX_W, DIM_W, and the state enum.
- Natural sub-module: conv_addr_gen (rowptr/col/k counters and address adder), leaving the FSM and capture logic in the top.

Test Plan:
- 4x4 image, base 0, mem[i]=i, win_ready=1: 4 windows.
  - Window (0,0) = {0,1,2,4,5,6,8,9,10}.
  - Window (1,1) = {5,6,7,9,10,11,13,14,15}.
  - First win_valid rises 10 edges after the start edge; done pulses after the 4th handshake.
- 5x3 image, base 100: 3 windows. The first address sequence is 100,101,102,105,106,107,110,111,112; win_row=0 for all windows.
- Backpressure: hold win_ready=0 for 20 cycles in OUT. win_data stays stable and ram_address does not change; after ready rises, exactly one handshake is accepted.
- base=16380, 3x3 image: addresses 16380,16381,16382,16383,0,1,2,3,4; exactly 1 window.
- img_w=2: err=1 and done pulses on the next cycle; no ram_address change and win_valid is never asserted.
- Deassert reset_n during FETCH of window 2: all outputs clear immediately and the FSM returns to IDLE. A new start replays from window (0,0).
